// File: rtl/mux_pipe.sv
// mux_pipe: N-way registered select with valid/ready handshake and one-entry skid buffer
module mux_pipe #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]        s,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        y,
  output logic                    y_err,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int SLOTS = 1 << SEL_W;
  logic [WIDTH-1:0] slot_data [SLOTS];
  logic [SLOTS-1:0] slot_err;
  logic [WIDTH-1:0] sel_data, skid_y;
  logic sel_err, skid_err, skid_valid, in_fire, load_out;
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i < NUM_IN) begin : g_in
      assign slot_data[i] = d[i*WIDTH +: WIDTH];
      assign slot_err[i]  = 1'b0;
    end else begin : g_oor
      assign slot_data[i] = '0;
      assign slot_err[i]  = 1'b1;
    end
  end
  assign sel_data = slot_data[s];
  assign sel_err  = slot_err[s];
  assign in_ready = reset_n & ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign load_out = ~out_valid | out_ready;
  always_ff @(posedge clk)
    if (!reset_n) begin
      out_valid  <= 1'b0;
      y          <= '0;
      y_err      <= 1'b0;
      skid_valid <= 1'b0;
      skid_y     <= '0;
      skid_err   <= 1'b0;
    end else if (load_out) begin
      out_valid <= skid_valid | in_fire;
      if (skid_valid) begin
        y          <= skid_y;
        y_err      <= skid_err;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        y     <= sel_data;
        y_err <= sel_err;
      end
    end else if (in_fire) begin
      skid_y     <= sel_data;
      skid_err   <= sel_err;
      skid_valid <= 1'b1;
    end
endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: randomized scoreboard bench for mux_pipe across four width/depth configurations
module tb_mux_pipe;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0][1023:0] d;
  logic [3:0][3:0] s;
  logic [3:0][63:0] y;
  logic [3:0] in_valid, in_ready, y_err, out_valid, out_ready;
  int wid [4] = '{32, 32, 8, 64};
  int nin [4] = '{4, 3, 2, 16};
  int sw  [4] = '{2, 2, 1, 4};
  logic [64:0] q [$];
  int nchecks = 0;
  int nerr = 0;
  bit prev_stall = 0;
  logic [63:0] stall_y;
  logic stall_err;
  always #5 clk = ~clk;
  mux_pipe #(.WIDTH(32), .NUM_IN(4)) u0 (.clk(clk), .reset_n(reset_n), .d(d[0][127:0]), .s(s[0][1:0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .y(y[0][31:0]), .y_err(y_err[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]));
  mux_pipe #(.WIDTH(32), .NUM_IN(3)) u1 (.clk(clk), .reset_n(reset_n), .d(d[1][95:0]), .s(s[1][1:0]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .y(y[1][31:0]), .y_err(y_err[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]));
  mux_pipe #(.WIDTH(8), .NUM_IN(2)) u2 (.clk(clk), .reset_n(reset_n), .d(d[2][15:0]), .s(s[2][0:0]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .y(y[2][7:0]), .y_err(y_err[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]));
  mux_pipe #(.WIDTH(64), .NUM_IN(16)) u3 (.clk(clk), .reset_n(reset_n), .d(d[3][1023:0]), .s(s[3][3:0]),
    .in_valid(in_valid[3]), .in_ready(in_ready[3]), .y(y[3][63:0]), .y_err(y_err[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]));
  function automatic logic [63:0] wmask(input int k);
    return (wid[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << wid[k]) - 64'd1);
  endfunction
  function automatic logic [63:0] yk(input int k);
    return y[k] & wmask(k);
  endfunction
  function automatic logic [64:0] ref_beat(input int k);
    int sv;
    logic [1023:0] t;
    sv = int'(s[k]) & ((1 << sw[k]) - 1);
    t = d[k] >> (sv * wid[k]);
    return (sv >= nin[k]) ? {1'b1, 64'd0} : {1'b0, t[63:0] & wmask(k)};
  endfunction
  task automatic rand_in(input int k);
    for (int j = 0; j < 32; j++) d[k][j*32 +: 32] = $urandom;
    s[k] = 4'($urandom_range(0, (1 << sw[k]) - 1));
  endtask
  task automatic cycle(input int k, output bit inf);
    bit outf;
    logic [64:0] e;
    #1;
    inf = in_valid[k] && in_ready[k];
    outf = out_valid[k] && out_ready[k];
    if (prev_stall) begin
      nchecks++;
      if (!out_valid[k] || yk(k) !== stall_y || y_err[k] !== stall_err) begin
        nerr++;
        $display("FAIL stall_hold dut%0d: got v=%b y=%h e=%b expected v=1 y=%h e=%b", k, out_valid[k], yk(k), y_err[k], stall_y, stall_err);
      end
    end
    if (outf) begin
      nchecks++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_beat dut%0d: got y=%h e=%b expected no beat", k, yk(k), y_err[k]);
      end else begin
        e = q.pop_front();
        if ({y_err[k], yk(k)} !== e) begin
          nerr++;
          $display("FAIL scoreboard dut%0d: got e=%b y=%h expected e=%b y=%h", k, y_err[k], yk(k), e[64], e[63:0]);
        end
      end
    end
    if (inf) q.push_back(ref_beat(k));
    prev_stall = out_valid[k] && !out_ready[k];
    stall_y = yk(k);
    stall_err = y_err[k];
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drain(input int k);
    bit f;
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b1;
    for (int i = 0; i < 40 && (q.size() > 0 || out_valid[k]); i++) cycle(k, f);
    nchecks++;
    if (q.size() != 0 || out_valid[k]) begin
      nerr++;
      $display("FAIL drain dut%0d: got %0d beats left expected 0", k, q.size());
    end
    q.delete();
    prev_stall = 0;
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      nchecks++;
      if (out_valid[k] !== 1'b0 || yk(k) !== 64'd0 || in_ready[k] !== 1'b0 || y_err[k] !== 1'b0) begin
        nerr++;
        $display("FAIL reset dut%0d: got v=%b y=%h r=%b e=%b expected 0 0 0 0", k, out_valid[k], yk(k), in_ready[k], y_err[k]);
      end
    end
    reset_n = 1'b1;
    #1;
    nchecks++;
    if (in_ready !== 4'hF) begin
      nerr++;
      $display("FAIL reset_release: got in_ready=%b expected 1111", in_ready);
    end
  endtask
  task automatic test_stream;
    bit f;
    prev_stall = 0;
    d[0] = '0;
    d[0][127:0] = {32'h44, 32'h33, 32'h22, 32'h11};
    out_ready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0 && i < 5) begin
        nchecks++;
        if (!out_valid[0] || yk(0) !== 64'(32'h11 * i) || y_err[0] !== 1'b0) begin
          nerr++;
          $display("FAIL stream beat%0d: got v=%b y=%h e=%b expected v=1 y=%h e=0", i, out_valid[0], yk(0), y_err[0], 32'h11 * i);
        end
      end
      nchecks++;
      if (in_ready[0] !== 1'b1) begin
        nerr++;
        $display("FAIL stream_ready cyc%0d: got %b expected 1", i, in_ready[0]);
      end
      in_valid[0] = (i < 4);
      s[0] = 4'(i % 4);
      cycle(0, f);
    end
    drain(0);
  endtask
  task automatic test_backpressure;
    bit f;
    int idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (c >= 2 && c <= 5) begin
        nchecks++;
        if (in_ready[0] !== 1'b0 || !out_valid[0] || yk(0) !== 64'h11) begin
          nerr++;
          $display("FAIL bp_full cyc%0d: got r=%b v=%b y=%h expected r=0 v=1 y=11", c, in_ready[0], out_valid[0], yk(0));
        end
      end
      if (c >= 6 && c <= 9) begin
        nchecks++;
        if (!out_valid[0]) begin
          nerr++;
          $display("FAIL bp_gap cyc%0d: got out_valid=0 expected 1", c);
        end
      end
      in_valid[0] = (idx < 4);
      s[0] = 4'(idx % 4);
      out_ready[0] = (c == 0) || (c >= 6);
      cycle(0, f);
      if (f) idx++;
    end
    nchecks++;
    if (idx != 4 || q.size() != 0) begin
      nerr++;
      $display("FAIL bp_count: got accepted=%0d pending=%0d expected 4 0", idx, q.size());
    end
    drain(0);
  endtask
  task automatic test_out_of_range;
    bit f;
    d[1] = '0;
    d[1][95:0] = {32'hA2, 32'hA1, 32'hA0};
    out_ready[1] = 1'b1;
    in_valid[1] = 1'b1;
    s[1] = 4'd3;
    cycle(1, f);
    nchecks++;
    if (!out_valid[1] || yk(1) !== 64'd0 || y_err[1] !== 1'b1) begin
      nerr++;
      $display("FAIL oor_beat: got v=%b y=%h e=%b expected v=1 y=0 e=1", out_valid[1], yk(1), y_err[1]);
    end
    s[1] = 4'd1;
    cycle(1, f);
    nchecks++;
    if (!out_valid[1] || yk(1) !== 64'hA1 || y_err[1] !== 1'b0) begin
      nerr++;
      $display("FAIL oor_next: got v=%b y=%h e=%b expected v=1 y=a1 e=0", out_valid[1], yk(1), y_err[1]);
    end
    drain(1);
  endtask
  task automatic test_back_to_back;
    bit f;
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) begin
        nchecks++;
        if (!out_valid[0] || in_ready[0] !== 1'b1) begin
          nerr++;
          $display("FAIL b2b cyc%0d: got v=%b r=%b expected 1 1", i, out_valid[0], in_ready[0]);
        end
      end
      rand_in(0);
      cycle(0, f);
    end
    drain(0);
  endtask
  task automatic test_reset_mid;
    bit f;
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_in(0);
      cycle(0, f);
    end
    in_valid[0] = 1'b0;
    #1;
    nchecks++;
    if (in_ready[0] !== 1'b0 || !out_valid[0]) begin
      nerr++;
      $display("FAIL mid_full: got r=%b v=%b expected r=0 v=1", in_ready[0], out_valid[0]);
    end
    reset_n = 1'b0;
    #1;
    nchecks++;
    if (in_ready[0] !== 1'b0) begin
      nerr++;
      $display("FAIL mid_in_reset: got in_ready=%b expected 0", in_ready[0]);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    nchecks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      nerr++;
      $display("FAIL mid_release: got v=%b r=%b expected v=0 r=1", out_valid[0], in_ready[0]);
    end
    q.delete();
    prev_stall = 0;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0, f);
    nchecks++;
    if (out_valid[0] !== 1'b0) begin
      nerr++;
      $display("FAIL mid_stale: got out_valid=%b expected 0", out_valid[0]);
    end
  endtask
  task automatic test_sweep(input int k, input int n);
    bit f;
    bit hold = 0;
    prev_stall = 0;
    for (int i = 0; i < n; i++) begin
      if (!hold) begin
        rand_in(k);
        in_valid[k] = ($urandom_range(0, 3) != 0);
      end
      out_ready[k] = $urandom_range(0, 1) == 1;
      cycle(k, f);
      hold = in_valid[k] && !f;
    end
    drain(k);
  endtask
  initial begin
    d = '0;
    s = '0;
    in_valid = '0;
    out_ready = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_sweep(1, 300);
    test_sweep(2, 1000);
    test_sweep(3, 1000);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/mux_pipe.md
Name: mux_pipe

Overview:
- Parametrised N-way selector with a registered output stage and a valid/ready handshake. Successor to the combinational 2-way select.
- Sits between pipeline stages of the RISC-V datapath, e.g. writeback-result or forwarding select across a stall boundary.
- Sustains one transfer per cycle under backpressure via a one-entry skid buffer.
- Flags out-of-range selects instead of aliasing them.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of data inputs, 2..16.
- SEL_W, $clog2(NUM_IN), select width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- d  input  NUM_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- s  input  SEL_W  select, sampled with the input transfer.
- in_valid  input  1  upstream offers d/s.
- in_ready  output  1  block can accept this cycle.
- y  output  WIDTH  selected data, registered.
- y_err  output  1  set when the transfer's s >= NUM_IN.
- out_valid  output  1  y/y_err valid.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset:
  - Reset is sampled on the rising clk edge while reset_n=0.
  - Clears out_valid=0, y=0, y_err=0, skid_valid=0, skid data=0.
  - in_ready=0 while reset_n=0; in_ready=1 from the first cycle after release.
  - Reset mid-transfer discards the output register and skid contents, with no partial transfer.
- Select:
  - sel_data = d[s*WIDTH +: WIDTH] when s < NUM_IN.
  - Otherwise sel_data=0 and err=1.
  - err travels with the data through both registers.
- Transfer rules:
  - Input transfer: in_valid & in_ready at the edge.
  - Output transfer: out_valid & out_ready at the edge.
- in_ready = ~skid_valid, driven from a register with no combinational path from out_ready.
- Latency: 1 cycle. Data accepted at edge N appears on y with out_valid=1 after edge N.
- Throughput: 1 transfer/cycle while out_ready=1.
- Per-edge update, with both registers treated as one FIFO of depth 2:
  - Output register empty (or being drained) and skid empty: input goes to the output register.
  - Output register full and not drained: input goes to skid; skid_valid=1.
  - Skid full and output register drained: skid moves to the output register; skid_valid=0. No input is accepted that cycle, since in_ready=0.
- Ordering is strictly FIFO; no transfer is dropped or duplicated.
- Simultaneous in/out transfer with skid empty: the output register takes the new input and out_valid stays 1.
- Stall: while out_valid=1 and out_ready=0, y and y_err hold stable.
- out_valid never drops without an output transfer.
- Full state (both entries occupied): in_ready=0. Upstream must hold d/s/in_valid; the block samples nothing.
- Empty state: out_valid=0. y holds its last value; its content is don't-care to consumers.
- in_valid while in_ready=0 has no effect.
- The s value is irrelevant when in_valid=0.

Test Plan:
- Reset then streaming:
  - Stimulus: hold reset_n=0 for 2 cycles; check out_valid=0, y=0, in_ready=0. Release, then drive d={0x44,0x33,0x22,0x11}, in_valid=1, s=0,1,2,3 on consecutive cycles, out_ready=1.
  - Required: y=0x11,0x22,0x33,0x44 on consecutive cycles starting one cycle after the first accept; in_ready stays 1; y_err=0.
- Backpressure and skid:
  - Stimulus: stream s=0..3 with out_ready=0 from the second cycle.
  - Required: after two accepts in_ready=0; y holds 0x11. Raise out_ready: sequence 0x11, 0x22, 0x33, 0x44 emerges in order with no gaps or loss.
- Out of range:
  - Stimulus: NUM_IN=3, s=3 with valid data.
  - Required: y=0, y_err=1 for that beat; the next beat with s=1 gives y_err=0.
- Simultaneous accept/drain:
  - Stimulus: out_valid=1, out_ready=1, in_valid=1 every cycle for 16 cycles with random s.
  - Required: 16 outputs match the reference select model; skid never fills.
- Reset mid-operation:
  - Stimulus: fill both entries, then pulse reset_n=0 for one cycle.
  - Required: out_valid=0 after the edge, in_ready=1 the cycle after release, no stale beat emitted.
- Width/depth sweep:
  - Stimulus: WIDTH=8 with NUM_IN=2, and WIDTH=64 with NUM_IN=16, random handshakes over 1000 cycles.
  - Required: the scoreboard matches and stalled outputs are stable.
